// File: rtl/transform_mb_scheduler_pkg.sv
// Shared definitions for the macroblock transform scheduler: residual class codes,
// item indices of the per-MB walk, watchdog limit and FSM state encoding.
package transform_mb_scheduler_pkg;

  localparam logic [3:0] RS_IDLE   = 4'd0;
  localparam logic [3:0] RS_I16DC  = 4'd1;
  localparam logic [3:0] RS_I16AC  = 4'd2;
  localparam logic [3:0] RS_LUMA   = 4'd3;
  localparam logic [3:0] RS_CDC_CB = 4'd4;
  localparam logic [3:0] RS_CDC_CR = 4'd5;
  localparam logic [3:0] RS_CAC_CB = 4'd6;
  localparam logic [3:0] RS_CAC_CR = 4'd7;

  localparam logic [4:0] ITEM_I16DC   = 5'd0;
  localparam logic [4:0] ITEM_LUMA0   = 5'd1;
  localparam logic [4:0] ITEM_LUMA15  = 5'd16;
  localparam logic [4:0] ITEM_CDC_CB  = 5'd17;
  localparam logic [4:0] ITEM_CDC_CR  = 5'd18;
  localparam logic [4:0] ITEM_CAC_CR0 = 5'd23;
  localparam logic [4:0] ITEM_LAST    = 5'd26;

  // Last watchdog value seen in WAIT_T before a timeout is declared (63rd cycle).
  localparam logic [5:0] WD_LIMIT = 6'd62;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSom   = 3'd1,
    StFetch = 3'd2,
    StWaitT = 3'd3,
    StEmit  = 3'd4,
    StDone  = 3'd5
  } sched_state_e;

endpackage

// File: rtl/transform_mb_seq_decode.sv
// Combinational decode of an MB item index into residual class, block indices,
// skip decision and DC flag.
module transform_mb_seq_decode
  import transform_mb_scheduler_pkg::*;
(
  input  logic [4:0] i_item,
  input  logic       i_i16,
  input  logic [3:0] i_cbp_luma,
  input  logic [1:0] i_cbp_chroma,
  output logic [3:0] o_residual_state,
  output logic [3:0] o_luma_idx,
  output logic [1:0] o_chroma_idx,
  output logic       o_skip,
  output logic       o_is_dc
);

  logic [3:0] w_luma_off;
  logic [1:0] w_cac_off;
  logic       w_chroma_none;

  // Item 16 wraps to 15 and items 23..26 alias 19..22 in the low bits.
  assign w_luma_off    = i_item[3:0] - 4'd1;
  assign w_cac_off     = i_item[1:0] - 2'd3;
  assign w_chroma_none = (i_cbp_chroma == 2'd0);

  always_comb begin
    o_residual_state = RS_IDLE;
    o_luma_idx       = 4'd0;
    o_chroma_idx     = 2'd0;
    o_skip           = 1'b0;
    o_is_dc          = 1'b0;
    if (i_item == ITEM_I16DC) begin
      o_residual_state = RS_I16DC;
      o_skip           = ~i_i16;
      o_is_dc          = 1'b1;
    end else if (i_item <= ITEM_LUMA15) begin
      o_residual_state = i_i16 ? RS_I16AC : RS_LUMA;
      o_luma_idx       = w_luma_off;
      o_skip           = ~i_i16 & ~i_cbp_luma[w_luma_off[3:2]];
    end else if (i_item == ITEM_CDC_CB) begin
      o_residual_state = RS_CDC_CB;
      o_skip           = w_chroma_none;
      o_is_dc          = 1'b1;
    end else if (i_item == ITEM_CDC_CR) begin
      o_residual_state = RS_CDC_CR;
      o_skip           = w_chroma_none;
      o_is_dc          = 1'b1;
    end else if (i_item <= ITEM_LAST) begin
      o_residual_state = (i_item < ITEM_CAC_CR0) ? RS_CAC_CB : RS_CAC_CR;
      o_chroma_idx     = w_cac_off;
      o_skip           = w_chroma_none;
    end
  end

endmodule

// File: rtl/transform_mb_scheduler.sv
// Walks the 27 residual items of a macroblock, handshaking coefficients, the transform
// datapath and the downstream residual stage, with a sticky transform watchdog.
module transform_mb_scheduler
  import transform_mb_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       mb_start,
  input  logic       i16,
  input  logic [3:0] cbp_luma,
  input  logic [1:0] cbp_chroma,
  input  logic       coeff_rdy,
  output logic       coeff_ack,
  output logic       tr_start,
  input  logic       tr_valid,
  output logic       start_of_MB,
  output logic [3:0] residual_state,
  output logic [3:0] luma4x4BlkIdx_residual,
  output logic [1:0] chroma4x4BlkIdx_residual,
  output logic       out_valid,
  output logic       out_zero,
  input  logic       out_ready,
  output logic       busy,
  output logic       mb_done,
  output logic       err
);

  sched_state_e r_state, w_state_nxt;
  logic [4:0]   r_item, w_item_nxt;
  logic         r_i16;
  logic [3:0]   r_cbp_luma;
  logic [1:0]   r_cbp_chroma;
  logic [5:0]   r_wd;
  logic         r_err;
  logic         r_zero, w_zero_nxt;
  logic         w_latch, w_fire, w_timeout, w_advance;
  logic [3:0]   w_rs, w_luma_idx;
  logic [1:0]   w_chroma_idx;
  logic         w_skip, w_is_dc, w_in_item;

  transform_mb_seq_decode u_decode (
    .i_item          (r_item),
    .i_i16           (r_i16),
    .i_cbp_luma      (r_cbp_luma),
    .i_cbp_chroma    (r_cbp_chroma),
    .o_residual_state(w_rs),
    .o_luma_idx      (w_luma_idx),
    .o_chroma_idx    (w_chroma_idx),
    .o_skip          (w_skip),
    .o_is_dc         (w_is_dc)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_item_nxt  = r_item;
    w_zero_nxt  = r_zero;
    w_latch     = 1'b0;
    w_fire      = 1'b0;
    w_timeout   = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      StIdle: begin
        if (mb_start) begin
          w_latch     = 1'b1;
          w_state_nxt = StSom;
        end
      end
      StSom: begin
        w_state_nxt = StFetch;
        w_item_nxt  = r_i16 ? ITEM_I16DC : ITEM_LUMA0;
      end
      StFetch: begin
        if (w_skip) begin
          if (w_is_dc) begin
            w_advance = 1'b1;
          end else begin
            w_zero_nxt  = 1'b1;
            w_state_nxt = StEmit;
          end
        end else if (coeff_rdy) begin
          w_fire      = 1'b1;
          w_state_nxt = StWaitT;
        end
      end
      StWaitT: begin
        // A watchdog expiry completes the item exactly like a late tr_valid.
        if (tr_valid || (r_wd == WD_LIMIT)) begin
          w_timeout = ~tr_valid;
          if (w_is_dc) begin
            w_advance = 1'b1;
          end else begin
            w_zero_nxt  = 1'b0;
            w_state_nxt = StEmit;
          end
        end
      end
      StEmit: begin
        if (out_ready) begin
          w_advance = 1'b1;
        end
      end
      StDone: begin
        w_state_nxt = StIdle;
        w_item_nxt  = ITEM_I16DC;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
    if (w_advance) begin
      if (r_item == ITEM_LAST) begin
        w_state_nxt = StDone;
      end else begin
        w_state_nxt = StFetch;
        w_item_nxt  = r_item + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_item       <= ITEM_I16DC;
      r_i16        <= 1'b0;
      r_cbp_luma   <= 4'd0;
      r_cbp_chroma <= 2'd0;
      r_wd         <= 6'd0;
      r_err        <= 1'b0;
      r_zero       <= 1'b0;
    end else if (ena) begin
      r_state <= w_state_nxt;
      r_item  <= w_item_nxt;
      r_zero  <= w_zero_nxt;
      if (w_latch) begin
        r_i16        <= i16;
        r_cbp_luma   <= cbp_luma;
        r_cbp_chroma <= cbp_chroma;
      end
      if (w_fire) begin
        r_wd <= 6'd0;
      end else if (r_state == StWaitT) begin
        r_wd <= r_wd + 6'd1;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign w_in_item = (r_state == StFetch) || (r_state == StWaitT) || (r_state == StEmit);

  assign coeff_ack                = ena & w_fire;
  assign tr_start                 = ena & w_fire;
  assign start_of_MB              = ena & (r_state == StSom);
  assign mb_done                  = ena & (r_state == StDone);
  assign out_valid                = (r_state == StEmit);
  assign out_zero                 = out_valid & r_zero;
  assign busy                     = (r_state != StIdle);
  assign err                      = r_err;
  assign residual_state           = w_in_item ? w_rs : RS_IDLE;
  assign luma4x4BlkIdx_residual   = w_in_item ? w_luma_idx : 4'd0;
  assign chroma4x4BlkIdx_residual = w_in_item ? w_chroma_idx : 2'd0;

endmodule

// File: tb/tb_transform_mb_scheduler.sv
// Scoreboard bench for transform_mb_scheduler: directed MBs push expected emits into a
// queue, a negedge monitor pops and compares every accepted residual block.
module tb_transform_mb_scheduler;
  import transform_mb_scheduler_pkg::*;

  logic       clk = 1'b0;
  logic       rst, ena, mb_start, i16;
  logic [3:0] cbp_luma;
  logic [1:0] cbp_chroma;
  logic       coeff_rdy, coeff_ack, tr_start, tr_valid, start_of_MB;
  logic [3:0] residual_state, luma_idx;
  logic [1:0] chroma_idx;
  logic       out_valid, out_zero, out_ready, busy, mb_done, err;

  int checks   = 0;
  int failures = 0;
  int n_trs, n_som, n_done, n_emit, n_zero;
  int tv_delay = 3;
  bit drop_req = 1'b0;

  // {residual_state, luma idx, chroma idx, out_zero}
  logic [10:0] exp_q[$];
  logic [17:0] outs;
  logic [3:0]  pulses;

  assign outs = {coeff_ack, tr_start, start_of_MB, residual_state, luma_idx, chroma_idx,
                 out_valid, out_zero, busy, mb_done, err};
  assign pulses = {tr_start, coeff_ack, start_of_MB, mb_done};

  always #5 clk = ~clk;

  transform_mb_scheduler dut (
    .clk                     (clk),
    .rst                     (rst),
    .ena                     (ena),
    .mb_start                (mb_start),
    .i16                     (i16),
    .cbp_luma                (cbp_luma),
    .cbp_chroma              (cbp_chroma),
    .coeff_rdy               (coeff_rdy),
    .coeff_ack               (coeff_ack),
    .tr_start                (tr_start),
    .tr_valid                (tr_valid),
    .start_of_MB             (start_of_MB),
    .residual_state          (residual_state),
    .luma4x4BlkIdx_residual  (luma_idx),
    .chroma4x4BlkIdx_residual(chroma_idx),
    .out_valid               (out_valid),
    .out_zero                (out_zero),
    .out_ready               (out_ready),
    .busy                    (busy),
    .mb_done                 (mb_done),
    .err                     (err)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Expected emits for one MB: 16 luma items then 8 chroma AC items; DC items never emit.
  task automatic push_expect(input logic iv, input logic [3:0] lv, input logic [1:0] cv);
    for (int k = 0; k < 16; k++) begin
      logic skip;
      skip = !iv && !lv[k>>2];
      exp_q.push_back({(iv ? RS_I16AC : RS_LUMA), 4'(k), 2'd0, skip});
    end
    for (int c = 0; c < 2; c++) begin
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back({((c == 0) ? RS_CAC_CB : RS_CAC_CR), 4'd0, 2'(b), (cv == 2'd0)});
      end
    end
  endtask

  task automatic start_mb(input logic iv, input logic [3:0] lv, input logic [1:0] cv);
    n_trs = 0; n_som = 0; n_done = 0; n_emit = 0; n_zero = 0;
    push_expect(iv, lv, cv);
    @(posedge clk); #1;
    mb_start = 1'b1; i16 = iv; cbp_luma = lv; cbp_chroma = cv;
    @(posedge clk); #1;
    mb_start = 1'b0;
  endtask

  task automatic finish_mb(input string name, input int etrs, input int eemit, input int ezero);
    int i = 0;
    while (n_done == 0 && i < 4000) begin
      @(negedge clk);
      i++;
    end
    if (n_done == 0) bound_fail({name, "_done"});
    @(negedge clk);
    chk({name, "_busy_after"}, int'(busy), 0);
    chk({name, "_tr_starts"}, n_trs, etrs);
    chk({name, "_emits"}, n_emit, eemit);
    chk({name, "_zero_emits"}, n_zero, ezero);
    chk({name, "_mb_done"}, n_done, 1);
    chk({name, "_start_of_mb"}, n_som, 1);
    chk({name, "_queue_left"}, exp_q.size(), 0);
  endtask

  task automatic wait_luma(input string name, input int n, input logic [3:0] rs);
    int i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!(busy && int'(luma_idx) == n && residual_state == rs) && i < 500);
    if (i >= 500) bound_fail(name);
  endtask

  task automatic wait_valid(input string name);
    int i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!out_valid && i < 200);
    if (i >= 200) bound_fail(name);
  endtask

  // Monitor / scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (tr_start) n_trs++;
        if (start_of_MB) n_som++;
        if (mb_done) n_done++;
        if (tr_start || coeff_ack) chk("ack_with_start", int'(coeff_ack), int'(tr_start));
        if (out_valid && out_ready && ena) begin
          n_emit++;
          if (out_zero) n_zero++;
          if (exp_q.size() == 0) begin
            bound_fail("emit_unexpected");
          end else begin
            logic [10:0] e;
            e = exp_q.pop_front();
            chk("emit", int'({residual_state, luma_idx, chroma_idx, out_zero}), int'(e));
          end
        end
      end
    end
  end

  // Transform model: tr_valid arrives tv_delay cycles after tr_start, or never if dropped.
  initial begin
    int cnt;
    cnt = 0;
    tr_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (tr_start) begin
        if (drop_req) begin
          drop_req = 1'b0;
          cnt = 0;
        end else begin
          cnt = tv_delay;
        end
      end
      @(posedge clk); #1;
      if (cnt > 0) begin
        cnt--;
        tr_valid = (cnt == 0);
      end else begin
        tr_valid = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    rst = 1'b1; ena = 1'b1; mb_start = 1'b0; i16 = 1'b0;
    cbp_luma = 4'd0; cbp_chroma = 2'd0; coeff_rdy = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("reset_outs", int'(outs), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_outs", int'(outs), 0);

    // I16 with empty CBP: DC + 16 AC transformed, chroma DC skipped, chroma AC zero.
    start_mb(1'b1, 4'b0000, 2'd0);
    finish_mb("i16_nocbp", 17, 24, 8);

    // Inter-style MB with cbp_luma=0101, chroma DC+AC.
    start_mb(1'b0, 4'b0101, 2'd2);
    finish_mb("cbp_0101", 18, 24, 8);

    // Downstream back-pressure on I16 AC block 5.
    start_mb(1'b1, 4'b0000, 2'd2);
    wait_luma("stall_wait_fetch", 5, RS_I16AC);
    @(posedge clk); #1 out_ready = 1'b0;
    wait_valid("stall_wait_valid");
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("stall_hold", int'({out_valid, residual_state, luma_idx, chroma_idx}),
          int'({1'b1, RS_I16AC, 4'd5, 2'd0}));
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("stall_accept_valid", int'(out_valid), 1);
    @(negedge clk);
    chk("stall_advanced_idx", int'(luma_idx), 6);
    finish_mb("stall", 27, 24, 0);

    // Transform result never arrives for item 1: watchdog sets err, MB still completes.
    drop_req = 1'b1;
    start_mb(1'b0, 4'b1111, 2'd2);
    cyc = 0;
    while (!tr_start && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!tr_start) bound_fail("timeout_first_start");
    chk("timeout_err_before", int'(err), 0);
    cyc = 0;
    while (!err && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("timeout_err_latency", cyc, 64);
    finish_mb("timeout", 26, 24, 0);
    chk("err_sticky", int'(err), 1);

    // Asynchronous reset during WAIT_T of item 5 (luma block 4).
    start_mb(1'b1, 4'b0000, 2'd2);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(tr_start && luma_idx == 4'd4) && cyc < 300);
    if (cyc >= 300) bound_fail("rst_wait_item5");
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_outs", int'(outs), 0);
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    n_trs = 0; n_som = 0; n_done = 0; n_emit = 0; n_zero = 0;
    repeat (10) @(negedge clk);
    chk("rst_quiet", n_trs + n_som + n_done + n_emit, 0);
    chk("rst_idle_outs", int'(outs), 0);
    start_mb(1'b1, 4'b0011, 2'd2);
    finish_mb("restart", 27, 24, 0);

    // Second mb_start while busy is ignored; ena=0 for 4 cycles freezes EMIT of luma 6.
    start_mb(1'b0, 4'b1111, 2'd2);
    wait_luma("freeze_wait_l2", 2, RS_LUMA);
    @(posedge clk); #1;
    mb_start = 1'b1; i16 = 1'b1; cbp_luma = 4'b0000; cbp_chroma = 2'd0;
    @(posedge clk); #1 mb_start = 1'b0;
    wait_luma("freeze_wait_l6", 6, RS_LUMA);
    @(posedge clk); #1 out_ready = 1'b0;
    wait_valid("freeze_wait_valid");
    @(posedge clk); #1;
    ena = 1'b0; out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("freeze_hold", int'({out_valid, busy, residual_state, luma_idx, pulses}),
          int'({1'b1, 1'b1, RS_LUMA, 4'd6, 4'd0}));
    end
    @(posedge clk); #1 ena = 1'b1;
    finish_mb("freeze", 26, 24, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
